// File: rtl/clk_cfg_seq_if.sv
// Software-side configuration bus of the clock configuration sequencer:
// target select values plus the request/status handshake.
interface clk_cfg_seq_if;
  logic       cfg_req;
  logic       cfg_sel_mux0;
  logic       cfg_sel_mux1;
  logic       cfg_sel_mux2;
  logic [1:0] cfg_sel_rosc;
  logic [1:0] cfg_clk_div;
  logic       err_clr;
  logic       busy;
  logic       done;
  logic       err;

  // Register block side: issues requests, observes progress
  modport master (
    output cfg_req, cfg_sel_mux0, cfg_sel_mux1, cfg_sel_mux2,
    output cfg_sel_rosc, cfg_clk_div, err_clr,
    input  busy, done, err
  );

  // Sequencer side
  modport slave (
    input  cfg_req, cfg_sel_mux0, cfg_sel_mux1, cfg_sel_mux2,
    input  cfg_sel_rosc, cfg_clk_div, err_clr,
    output busy, done, err
  );
endinterface

// File: rtl/clk_cfg_seq.sv
// Clock configuration sequencer: applies a new ROSC / xclk / divider /
// system-mux configuration in a glitch-safe order. The system clock is
// parked on ROSC (sel_mux0=0) before any source or divider change, xclk is
// qualified before it is selected, and a missing xclk aborts the change
// with the system clock still parked.
module clk_cfg_seq #(
  parameter int SETTLE_CYC = 16,
  parameter int XCLK_TMO   = 1024,
  parameter int QUAL_CNT   = 4
) (
  input  logic                clk_mux1,
  input  logic                rst_n,
  clk_cfg_seq_if.slave        cfg,
  input  logic                xclk_alive,
  output logic                sel_mux0,
  output logic                sel_mux1,
  output logic                sel_mux2,
  output logic [1:0]          sel_rosc,
  output logic [1:0]          clk_div
);

  localparam int SET_W  = $clog2(SETTLE_CYC);
  localparam int TMO_W  = $clog2(XCLK_TMO);
  // One extra code so the counter can actually hold QUAL_CNT itself.
  localparam int QUAL_W = $clog2(QUAL_CNT + 1);

  localparam logic [SET_W-1:0]  SETTLE_LD = SET_W'(SETTLE_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(XCLK_TMO - 1);
  localparam logic [QUAL_W-1:0] QUAL_LAST = QUAL_W'(QUAL_CNT);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PARK    = 3'd1;
  localparam logic [2:0] ST_SRC     = 3'd2;
  localparam logic [2:0] ST_QUAL    = 3'd3;
  localparam logic [2:0] ST_SWITCH  = 3'd4;
  localparam logic [2:0] ST_RELEASE = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;
  localparam logic [2:0] ST_ABORT   = 3'd7;

  logic [2:0]        state;
  logic [SET_W-1:0]  settle_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [QUAL_W-1:0] qual_cnt;
  logic [QUAL_W-1:0] qual_nxt;
  logic              settle_zero;

  logic              xclk_alive_p0;
  logic              xclk_alive_p1;

  logic              tgt_mux0;
  logic              tgt_mux1;
  logic              tgt_mux2;
  logic [1:0]        tgt_rosc;
  logic [1:0]        tgt_div;

  logic              busy_q;
  logic              done_q;
  logic              err_q;

  // Saturating counter helpers: counters stop at their terminal value.
  function automatic logic [SET_W-1:0] settle_dec(input logic [SET_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  function automatic logic [TMO_W-1:0] tmo_inc(input logic [TMO_W-1:0] v);
    return (v == TMO_LAST) ? v : v + 1'b1;
  endfunction

  function automatic logic [QUAL_W-1:0] qual_inc(input logic [QUAL_W-1:0] v);
    return (v == QUAL_LAST) ? v : v + 1'b1;
  endfunction

  assign settle_zero = (settle_cnt == '0);
  assign cfg.busy    = busy_q;
  assign cfg.done    = done_q;
  assign cfg.err     = err_q;

  // Two-flop synchronizer for the asynchronous xclk-present flag.
  always_ff @(posedge clk_mux1 or negedge rst_n) begin
    if (!rst_n) begin
      xclk_alive_p0 <= 1'b0;
      xclk_alive_p1 <= 1'b0;
    end else begin
      xclk_alive_p0 <= xclk_alive;
      xclk_alive_p1 <= xclk_alive_p0;
    end
  end

  // Qualify count for this cycle: consecutive alive samples, cleared on a gap.
  always_comb begin
    qual_nxt = '0;
    if (xclk_alive_p1) qual_nxt = qual_inc(qual_cnt);
  end

  // Sequencer FSM: entry actions are applied on the transition edge.
  always_ff @(posedge clk_mux1 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      qual_cnt   <= '0;
      tgt_mux0   <= 1'b0;
      tgt_mux1   <= 1'b0;
      tgt_mux2   <= 1'b0;
      tgt_rosc   <= 2'b11;
      tgt_div    <= 2'b11;
      sel_mux0   <= 1'b0;
      sel_mux1   <= 1'b0;
      sel_mux2   <= 1'b0;
      sel_rosc   <= 2'b11;
      clk_div    <= 2'b11;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg.cfg_req) begin
            tgt_mux0   <= cfg.cfg_sel_mux0;
            tgt_mux1   <= cfg.cfg_sel_mux1;
            tgt_mux2   <= cfg.cfg_sel_mux2;
            tgt_rosc   <= cfg.cfg_sel_rosc;
            tgt_div    <= cfg.cfg_clk_div;
            busy_q     <= 1'b1;
            sel_mux0   <= 1'b0;
            settle_cnt <= SETTLE_LD;
            state      <= ST_PARK;
          end
        end
        ST_PARK: begin
          if (settle_zero) begin
            sel_rosc   <= tgt_rosc;
            sel_mux2   <= tgt_mux2;
            settle_cnt <= SETTLE_LD;
            state      <= ST_SRC;
          end else begin
            settle_cnt <= settle_dec(settle_cnt);
          end
        end
        ST_SRC: begin
          if (settle_zero) begin
            if (tgt_mux1) begin
              qual_cnt <= '0;
              tmo_cnt  <= '0;
              state    <= ST_QUAL;
            end else begin
              sel_mux1   <= tgt_mux1;
              clk_div    <= tgt_div;
              settle_cnt <= SETTLE_LD;
              state      <= ST_SWITCH;
            end
          end else begin
            settle_cnt <= settle_dec(settle_cnt);
          end
        end
        ST_QUAL: begin
          qual_cnt <= qual_nxt;
          tmo_cnt  <= tmo_inc(tmo_cnt);
          // Qualification is checked first so it wins a same-cycle tie.
          if (qual_nxt == QUAL_LAST) begin
            sel_mux1   <= tgt_mux1;
            clk_div    <= tgt_div;
            settle_cnt <= SETTLE_LD;
            state      <= ST_SWITCH;
          end else if (tmo_cnt == TMO_LAST) begin
            state <= ST_ABORT;
          end
        end
        ST_SWITCH: begin
          if (settle_zero) begin
            sel_mux0   <= tgt_mux0;
            settle_cnt <= SETTLE_LD;
            state      <= ST_RELEASE;
          end else begin
            settle_cnt <= settle_dec(settle_cnt);
          end
        end
        ST_RELEASE: begin
          if (settle_zero) state <= ST_DONE;
          else             settle_cnt <= settle_dec(settle_cnt);
        end
        ST_DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        ST_ABORT: begin
          // Leave the system clock parked on ROSC; new ROSC/mux2 stay applied.
          sel_mux1 <= 1'b0;
          sel_mux0 <= 1'b0;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky error: set by an abort (set beats a simultaneous clear).
  always_ff @(posedge clk_mux1 or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state == ST_ABORT) begin
      err_q <= 1'b1;
    end else if (cfg.err_clr) begin
      err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clk_cfg_seq.sv
// Directed bench for clk_cfg_seq with default parameters (SETTLE_CYC=16,
// XCLK_TMO=1024, QUAL_CNT=4). Edge 0 is the accepting clock edge.
module tb_clk_cfg_seq;
  logic       clk_mux1;
  logic       rst_n;
  logic       xclk_alive;
  logic       sel_mux0;
  logic       sel_mux1;
  logic       sel_mux2;
  logic [1:0] sel_rosc;
  logic [1:0] clk_div;

  int n_cmp;
  int n_err;
  int lat;

  logic       prev_vld;
  logic       prev_mux0;
  logic       prev_mux1;
  logic [1:0] prev_div;

  clk_cfg_seq_if cfg_if ();

  clk_cfg_seq dut (
    .clk_mux1   (clk_mux1),
    .rst_n      (rst_n),
    .cfg        (cfg_if),
    .xclk_alive (xclk_alive),
    .sel_mux0   (sel_mux0),
    .sel_mux1   (sel_mux1),
    .sel_mux2   (sel_mux2),
    .sel_rosc   (sel_rosc),
    .clk_div    (clk_div)
  );

  initial clk_mux1 = 1'b0;
  always #5 clk_mux1 = ~clk_mux1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // sel_mux1 / clk_div may only move while the system clock is parked.
  always @(negedge clk_mux1) begin
    if (rst_n && prev_vld && (sel_mux1 !== prev_mux1 || clk_div !== prev_div)) begin
      check_eq("glitch_prev_mux0", {31'd0, prev_mux0}, 32'd0);
      check_eq("glitch_cur_mux0", {31'd0, sel_mux0}, 32'd0);
    end
    prev_vld  = rst_n;
    prev_mux0 = sel_mux0;
    prev_mux1 = sel_mux1;
    prev_div  = clk_div;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_mux1);
    #1;
  endtask

  // Present a request before edge 0; returns just after edge 0.
  task automatic start_req(input logic m0, input logic m1, input logic m2,
                           input logic [1:0] rosc, input logic [1:0] div);
    @(negedge clk_mux1);
    cfg_if.cfg_sel_mux0 = m0;
    cfg_if.cfg_sel_mux1 = m1;
    cfg_if.cfg_sel_mux2 = m2;
    cfg_if.cfg_sel_rosc = rosc;
    cfg_if.cfg_clk_div  = div;
    cfg_if.cfg_req      = 1'b1;
    @(posedge clk_mux1);
    #1;
    cfg_if.cfg_req = 1'b0;
  endtask

  // Count edges after edge 0 until done is seen; optional 1,1,0 xclk toggling.
  task automatic wait_done(input int budget, input bit tog, output int n_edge);
    bit seen;
    seen   = 1'b0;
    n_edge = -1;
    for (int n = 1; n <= budget && !seen; n++) begin
      if (tog) begin
        @(negedge clk_mux1);
        xclk_alive = ((n % 3) != 0);
      end
      @(posedge clk_mux1);
      #1;
      if (cfg_if.done) begin
        seen   = 1'b1;
        n_edge = n;
      end
    end
    if (!seen) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    prev_vld = 1'b0;
    rst_n = 1'b0;
    xclk_alive = 1'b0;
    cfg_if.cfg_req = 1'b0;
    cfg_if.cfg_sel_mux0 = 1'b0;
    cfg_if.cfg_sel_mux1 = 1'b0;
    cfg_if.cfg_sel_mux2 = 1'b0;
    cfg_if.cfg_sel_rosc = 2'b00;
    cfg_if.cfg_clk_div  = 2'b00;
    cfg_if.err_clr = 1'b0;
    repeat (3) @(negedge clk_mux1);
    rst_n = 1'b1;
    step(2);

    // Reset defaults
    check_eq("rst_mux0", {31'd0, sel_mux0}, 32'd0);
    check_eq("rst_mux1", {31'd0, sel_mux1}, 32'd0);
    check_eq("rst_mux2", {31'd0, sel_mux2}, 32'd0);
    check_eq("rst_rosc", {30'd0, sel_rosc}, 32'd3);
    check_eq("rst_div", {30'd0, clk_div}, 32'd3);
    check_eq("rst_busy", {31'd0, cfg_if.busy}, 32'd0);
    check_eq("rst_done", {31'd0, cfg_if.done}, 32'd0);
    check_eq("rst_err", {31'd0, cfg_if.err}, 32'd0);

    // Bring sel_mux0 to 1 with a plain ROSC configuration
    start_req(1'b1, 1'b0, 1'b0, 2'b11, 2'b11);
    wait_done(200, 1'b0, lat);
    check_eq("setup_lat", lat, 32'd65);
    check_eq("setup_mux0", {31'd0, sel_mux0}, 32'd1);

    // ROSC target: exact edge timing of every change
    start_req(1'b1, 1'b0, 1'b0, 2'b01, 2'b01);
    check_eq("rosc_mux0_park", {31'd0, sel_mux0}, 32'd0);
    check_eq("rosc_busy_e0", {31'd0, cfg_if.busy}, 32'd1);
    step(15);
    check_eq("rosc_sel_e15", {30'd0, sel_rosc}, 32'd3);
    step(1);
    check_eq("rosc_sel_e16", {30'd0, sel_rosc}, 32'd1);
    step(15);
    check_eq("rosc_div_e31", {30'd0, clk_div}, 32'd3);
    step(1);
    check_eq("rosc_div_e32", {30'd0, clk_div}, 32'd1);
    step(15);
    check_eq("rosc_mux0_e47", {31'd0, sel_mux0}, 32'd0);
    step(1);
    check_eq("rosc_mux0_e48", {31'd0, sel_mux0}, 32'd1);
    step(16);
    check_eq("rosc_done_e64", {31'd0, cfg_if.done}, 32'd0);
    check_eq("rosc_busy_e64", {31'd0, cfg_if.busy}, 32'd1);
    step(1);
    check_eq("rosc_done_e65", {31'd0, cfg_if.done}, 32'd1);
    check_eq("rosc_busy_e65", {31'd0, cfg_if.busy}, 32'd0);
    step(1);
    check_eq("rosc_done_e66", {31'd0, cfg_if.done}, 32'd0);

    // xclk target with xclk present: 4 qualify cycles add to the latency
    xclk_alive = 1'b1;
    step(4);
    start_req(1'b1, 1'b1, 1'b1, 2'b10, 2'b10);
    step(16);
    check_eq("xok_mux2_e16", {31'd0, sel_mux2}, 32'd1);
    check_eq("xok_mux1_e16", {31'd0, sel_mux1}, 32'd0);
    wait_done(200, 1'b0, lat);
    check_eq("xok_lat", lat + 16, 32'd69);
    check_eq("xok_mux1", {31'd0, sel_mux1}, 32'd1);
    check_eq("xok_mux0", {31'd0, sel_mux0}, 32'd1);
    check_eq("xok_div", {30'd0, clk_div}, 32'd2);
    check_eq("xok_err", {31'd0, cfg_if.err}, 32'd0);

    // xclk dead: abort after the full timeout, clock stays parked
    xclk_alive = 1'b0;
    step(4);
    start_req(1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    wait_done(1500, 1'b0, lat);
    check_eq("xdead_lat", lat, 32'd1057);
    check_eq("xdead_mux1", {31'd0, sel_mux1}, 32'd0);
    check_eq("xdead_mux0", {31'd0, sel_mux0}, 32'd0);
    check_eq("xdead_rosc", {30'd0, sel_rosc}, 32'd0);
    check_eq("xdead_mux2", {31'd0, sel_mux2}, 32'd0);
    check_eq("xdead_div", {30'd0, clk_div}, 32'd2);
    check_eq("xdead_err", {31'd0, cfg_if.err}, 32'd1);
    check_eq("xdead_busy", {31'd0, cfg_if.busy}, 32'd0);
    @(negedge clk_mux1);
    cfg_if.err_clr = 1'b1;
    @(negedge clk_mux1);
    cfg_if.err_clr = 1'b0;
    check_eq("errclr", {31'd0, cfg_if.err}, 32'd0);

    // Toggling xclk (1,1,0) never qualifies; err_clr held high loses to the set
    cfg_if.err_clr = 1'b1;
    start_req(1'b1, 1'b1, 1'b1, 2'b01, 2'b01);
    wait_done(1500, 1'b1, lat);
    check_eq("xtog_lat", lat, 32'd1057);
    check_eq("xtog_err_setwins", {31'd0, cfg_if.err}, 32'd1);
    cfg_if.err_clr = 1'b0;
    check_eq("xtog_mux1", {31'd0, sel_mux1}, 32'd0);
    check_eq("xtog_mux2", {31'd0, sel_mux2}, 32'd1);

    // Request while busy is ignored; success does not clear err
    xclk_alive = 1'b0;
    start_req(1'b1, 1'b0, 1'b0, 2'b01, 2'b00);
    step(4);
    cfg_if.cfg_sel_mux0 = 1'b0;
    cfg_if.cfg_sel_rosc = 2'b10;
    cfg_if.cfg_clk_div  = 2'b11;
    cfg_if.cfg_req      = 1'b1;
    step(1);
    cfg_if.cfg_req = 1'b0;
    wait_done(200, 1'b0, lat);
    check_eq("busy_lat", lat + 5, 32'd65);
    check_eq("busy_rosc", {30'd0, sel_rosc}, 32'd1);
    check_eq("busy_div", {30'd0, clk_div}, 32'd0);
    check_eq("busy_mux0", {31'd0, sel_mux0}, 32'd1);
    check_eq("busy_err_kept", {31'd0, cfg_if.err}, 32'd1);
    step(1);
    check_eq("busy_idle", {31'd0, cfg_if.busy}, 32'd0);
    start_req(1'b0, 1'b0, 1'b0, 2'b10, 2'b11);
    wait_done(200, 1'b0, lat);
    check_eq("after_lat", lat, 32'd65);
    check_eq("after_rosc", {30'd0, sel_rosc}, 32'd2);
    check_eq("after_div", {30'd0, clk_div}, 32'd3);

    // Reset during SWITCH returns everything to reset values at once
    xclk_alive = 1'b1;
    step(4);
    start_req(1'b1, 1'b1, 1'b1, 2'b00, 2'b01);
    step(40);
    check_eq("mid_mux1_pre", {31'd0, sel_mux1}, 32'd1);
    check_eq("mid_busy_pre", {31'd0, cfg_if.busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_mux0", {31'd0, sel_mux0}, 32'd0);
    check_eq("mid_mux1", {31'd0, sel_mux1}, 32'd0);
    check_eq("mid_mux2", {31'd0, sel_mux2}, 32'd0);
    check_eq("mid_rosc", {30'd0, sel_rosc}, 32'd3);
    check_eq("mid_div", {30'd0, clk_div}, 32'd3);
    check_eq("mid_busy", {31'd0, cfg_if.busy}, 32'd0);
    check_eq("mid_err", {31'd0, cfg_if.err}, 32'd0);
    @(negedge clk_mux1);
    rst_n = 1'b1;
    step(2);
    start_req(1'b1, 1'b0, 1'b1, 2'b10, 2'b10);
    wait_done(200, 1'b0, lat);
    check_eq("post_lat", lat, 32'd65);
    check_eq("post_mux0", {31'd0, sel_mux0}, 32'd1);
    check_eq("post_mux2", {31'd0, sel_mux2}, 32'd1);
    check_eq("post_div", {30'd0, clk_div}, 32'd2);

    step(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
